uart_tx_ctrl: RTL

Frame controller for an asynchronous serial transmitter. It sits directly upstream of the shared `counter` block, which it uses as its bit-period (baud) timer. It drives that counter's `cen`, `init0` and `limit` inputs and consumes its `endCnt`. It accepts one parallel byte per request and shifts it out LSB first as start, data, optional even parity and stop bits.

---
 rtl/uart_tx_if.sv | 28 ++
 rtl/uart_tx_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/uart_tx_if.sv
// Handshake and counter-control bundle between the UART frame controller and
// its requester / shared baud counter.
interface uart_tx_if #(
    parameter int n     = 12,
    parameter int dataW = 8
);
    logic             txStart;
    logic [dataW-1:0] txData;
    logic             parityEn;
    logic [n-1:0]     baudLimit;
    logic             cntEnd;
    logic             cntCen;
    logic             cntInit0;
    logic [n-1:0]     cntLimit;
    logic             txd;
    logic             busy;
    logic             done;

    modport master (
        output txStart, txData, parityEn, baudLimit, cntEnd,
        input  cntCen, cntInit0, cntLimit, txd, busy, done
    );

    modport slave (
        input  txStart, txData, parityEn, baudLimit, cntEnd,
        output cntCen, cntInit0, cntLimit, txd, busy, done
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// Serial frame controller: start, LSB-first data, optional even parity, stop.
// Bit timing comes from an external counter driven through cntCen/cntInit0/cntLimit.
//
// state  | meaning
// IDLE   | line high, counter held clear, waiting for txStart
// START  | start bit (txd=0)
// DATA   | data bits, shreg[0] on the line
// PARITY | even-parity bit
// STOP   | stop bit (txd=1); done pulses in the following IDLE cycle
module uart_tx_ctrl #(
    parameter int n     = 12,
    parameter int dataW = 8
) (
    input  logic       clk,
    input  logic       rst,
    uart_tx_if.slave   bus
);
    localparam int IW = (dataW > 1) ? $clog2(dataW) : 1;
    localparam int NX = (dataW > 1) ? 1 : 0;
    localparam logic [IW-1:0] LAST_IDX = IW'(dataW - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state;
    logic [dataW-1:0] shreg;
    logic [IW-1:0]    idx;
    logic             par_bit;
    logic             par_en;
    logic             txd_r;
    logic             busy_r;
    logic             done_r;
    logic             cen_r;
    logic             init0_r;
    logic [n-1:0]     limit_r;

    assign bus.txd      = txd_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.cntCen   = cen_r;
    assign bus.cntInit0 = init0_r;
    assign bus.cntLimit = limit_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            idx     <= '0;
            par_bit <= 1'b0;
            par_en  <= 1'b0;
            txd_r   <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cen_r   <= 1'b0;
            init0_r <= 1'b1;
            limit_r <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.txStart) begin
                        shreg   <= bus.txData;
                        par_en  <= bus.parityEn;
                        par_bit <= ^bus.txData;
                        limit_r <= bus.baudLimit;
                        idx     <= '0;
                        state   <= START;
                        txd_r   <= 1'b0;
                        busy_r  <= 1'b1;
                        cen_r   <= 1'b1;
                        init0_r <= 1'b0;
                    end
                end
                START: begin
                    if (bus.cntEnd) begin
                        state <= DATA;
                        txd_r <= shreg[0];
                    end
                end
                DATA: begin
                    if (bus.cntEnd) begin
                        if (idx == LAST_IDX) begin
                            if (par_en) begin
                                state <= PARITY;
                                txd_r <= par_bit;
                            end else begin
                                state <= STOP;
                                txd_r <= 1'b1;
                            end
                        end else begin
                            // next data bit goes out on the same edge as the shift
                            shreg <= shreg >> 1;
                            idx   <= idx + IW'(1);
                            txd_r <= shreg[NX];
                        end
                    end
                end
                PARITY: begin
                    if (bus.cntEnd) begin
                        state <= STOP;
                        txd_r <= 1'b1;
                    end
                end
                STOP: begin
                    if (bus.cntEnd) begin
                        state   <= IDLE;
                        txd_r   <= 1'b1;
                        busy_r  <= 1'b0;
                        cen_r   <= 1'b0;
                        init0_r <= 1'b1;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    txd_r   <= 1'b1;
                    busy_r  <= 1'b0;
                    cen_r   <= 1'b0;
                    init0_r <= 1'b1;
                end
            endcase
        end
    end
endmodule
